// File: rtl/fixed_add_arb_pkg.sv
// Shared constants and slot-state encoding for the fixed-point add arbiter.
package fixed_add_arb_pkg;

    localparam int DATA_W = 16;
    localparam int ID_W   = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/fixedAdd16.sv
// 16-bit two's-complement fixed-point adder; overflow wraps modulo 2^16.
module fixedAdd16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/fixed_add_arb_rr_grant.sv
// Round-robin one-hot grant: search starts one past the pointer.
module rr_grant
    import fixed_add_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    valid_i,
    input  logic [ID_W-1:0] ptr_i,
    input  logic            en_i,
    output logic [N-1:0]    grant_o
);

    always_comb begin
        logic found;
        int   idx;
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (en_i && !found && valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fixed_add_arb.sv
// Round-robin arbiter feeding one fixedAdd16 with a single output slot.
// Optional FIXED_ADD_ARB_PERF_EN adds a saturating op_cnt transfer counter.
module fixed_add_arb
    import fixed_add_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [DW-1:0]     rsp_data,
    output logic [ID_W-1:0]   rsp_id,
    input  logic              rsp_ready
`ifdef FIXED_ADD_ARB_PERF_EN
    ,
    output logic [31:0]       op_cnt
`endif
);

    slot_state_e     state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [ID_W-1:0] id_q, id_d;

    logic            grant_en;
    logic [NREQ-1:0] grant;
    logic            xfer;
    logic [DW-1:0]   a_mux, b_mux, sum;
    logic [ID_W-1:0] gnt_id;

    // Slot may refill in the same cycle it drains; nothing granted in reset.
    assign grant_en = rst_n & ((state_q == EMPTY) | rsp_ready);

    rr_grant #(.N(NREQ)) u_rr (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .en_i    (grant_en),
        .grant_o (grant)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    always_comb begin
        a_mux  = '0;
        b_mux  = '0;
        gnt_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_mux  = req_a[i*DW +: DW];
                b_mux  = req_b[i*DW +: DW];
                gnt_id = ID_W'(i);
            end
        end
    end

    fixedAdd16 u_add (
        .a_i   (a_mux),
        .b_i   (b_mux),
        .sum_o (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= ID_W'(NREQ - 1);
            data_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (xfer) state_d = FULL;
            FULL:  if (rsp_ready && !xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        ptr_d  = ptr_q;
        data_d = data_q;
        id_d   = id_q;
        if (xfer) begin
            ptr_d  = gnt_id;
            data_d = sum;
            id_d   = gnt_id;
        end
    end

    always_comb begin
        rsp_valid = (state_q == FULL);
        rsp_data  = data_q;
        rsp_id    = id_q;
    end

`ifdef FIXED_ADD_ARB_PERF_EN
    logic [31:0] op_cnt_q, op_cnt_d;

    always_comb begin
        op_cnt_d = op_cnt_q;
        if (xfer && op_cnt_q != 32'hFFFF_FFFF) op_cnt_d = op_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_cnt_q <= '0;
        else        op_cnt_q <= op_cnt_d;
    end

    assign op_cnt = op_cnt_q;
`endif

endmodule

// File: doc/fixed_add_arb.md
FIXED_ADD_ARB -- requirements
Module: fixed_add_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (legal 2..8).
REQ-002 The block SHALL have parameter DW, default 16, meaning the operand/result width (fixed at 16, matching fixedAdd16).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port req_valid, input, NREQ bits, SHALL mean that requester i has an operand pair pending.
REQ-006 Port req_a, input, NREQ*DW bits, SHALL carry operand a of requester i in slice [i*DW +: DW].
REQ-007 Port req_b, input, NREQ*DW bits, SHALL carry operand b of requester i in slice [i*DW +: DW].
REQ-008 Port req_ready, output, NREQ bits, SHALL be a one-hot grant (or zero) showing the pair accepted this cycle.
REQ-009 Port rsp_valid, output, 1 bit, SHALL mean that rsp_data/rsp_id hold a result.
REQ-010 Port rsp_data, output, DW bits, SHALL be the registered fixedAdd16 result.
REQ-011 Port rsp_id, output, 3 bits, SHALL be the index of the requester that owns rsp_data.
REQ-012 Port rsp_ready, input, 1 bit, SHALL be the consumer's acceptance of the result.

Function
REQ-013 A transfer SHALL occur on requester i when req_valid[i] & req_ready[i] are both high.
REQ-014 req_ready SHALL be combinational from req_valid, the RR pointer and the output-slot state, and SHALL never depend on rsp_data.
REQ-015 FSM states SHALL be EMPTY (slot free) and FULL (rsp_valid=1).
REQ-016 A grant SHALL be allowed when the state is EMPTY, or when it is FULL and rsp_ready=1 (same-cycle drain and refill).
REQ-017 The grant SHALL be round-robin: the search starts at pointer+1 mod NREQ, and the first requester with valid set wins.
REQ-018 On a transfer, the pointer SHALL load the granted index; otherwise it SHALL hold.
REQ-019 Latency SHALL be 1 cycle: a transfer in cycle N gives rsp_valid=1 in N+1, with rsp_data = fixedAdd16(a,b) and rsp_id = i.
REQ-020 FULL with rsp_ready=0 SHALL hold rsp_data/rsp_id stable and force req_ready to 0.
REQ-021 FULL with rsp_ready=1 and no transfer SHALL go to EMPTY and clear rsp_valid.
REQ-022 Sustained throughput SHALL be one add per cycle while rsp_ready=1.
REQ-023 A requester dropping req_valid without a grant SHALL be legal and SHALL leave the pointer unchanged.
REQ-024 Operands SHALL pass to fixedAdd16 unmodified; overflow behaviour SHALL be fixedAdd16's own.

Reset
REQ-025 While rst_n=0, the block SHALL force state=EMPTY, rsp_valid=0, rsp_data=0, rsp_id=0, pointer=NREQ-1 (so requester 0 has first priority) and req_ready=0.
REQ-026 A reset asserted mid-operation SHALL discard any held result without producing a response.

Configuration
REQ-027 With macro FIXED_ADD_ARB_PERF_EN defined, the block SHALL add output op_cnt (32 bits), which counts completed transfers, saturates at 32'hFFFFFFFF and resets to 0.
REQ-028 Without FIXED_ADD_ARB_PERF_EN, the port and the counter SHALL be absent and the function SHALL be otherwise identical.

Structure
REQ-029 A shared package SHALL hold the state encoding (EMPTY=1'b0, FULL=1'b1), DW=16 and the ID width constant 3.
REQ-030 Round-robin grant logic SHALL be a sub-module rr_grant (inputs: valid vector, pointer, enable; output: one-hot grant).
REQ-031 The block SHALL use one fixedAdd16 instance, fed by the granted operand mux.

Verification
REQ-032 Requester 0 only, a=16'h0000, b=16'h34CD, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=16'h34CD, rsp_id=0.
REQ-033 Requester 2, a=16'h34CD, b=16'h84CD -> rsp_data equals a standalone fixedAdd16 output for the same operands, rsp_id=2.
REQ-034 All 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle, with rsp_id following one cycle later.
REQ-035 rsp_ready=0 for 3 cycles while FULL -> req_ready=0 and rsp_data stable; on rsp_ready=1 the next grant happens in the same cycle.
REQ-036 rst_n pulsed low while FULL -> rsp_valid=0 immediately; after release, requester 0 wins the first grant when all are valid.
REQ-037 With FIXED_ADD_ARB_PERF_EN, 10 transfers -> op_cnt=10; with op_cnt preset near 32'hFFFFFFFF by force, it saturates and does not wrap.
